hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//   Generates the pipeline hold/bubble controls, including DECEX_stall, consumed by the IF/DEC and DEC/EX
//   pipeline registers. DECEX_stall=1 loads an all-zero NOP into DEC/EX.
//   Detects RAW hazards between the DEC-stage instruction and older in-flight writers.
//   Runs a flush state machine that squashes wrong-path instructions after a taken branch, jump or jr.
//   Keeps saturating stall-cycle and flush-cycle performance counters.
// PARAMETERS
//   FORWARDING    1  1: EX forwarding exists, stall on load-use only; 0: stall on any in-flight writer
//   FLUSH_CYCLES  1  total cycles IFDEC_flush is held per redirect (range 1..7)
// PORTS
//   Clk            in   1   system clock, all state on posedge
//   Reset          in   1   synchronous, active-high
//   RsIn           in   5   DEC-stage rs field
//   RtIn           in   5   DEC-stage rt field
//   UseRsIn        in   1   DEC instruction reads rs
//   UseRtIn        in   1   DEC instruction reads rt
//   DECEX_RegDst   in   5   destination register of the instruction in EX (DEC/EX output)
//   DECEX_RegWrite in   1   EX instruction writes the register file
//   DECEX_MemRead  in   1   EX instruction is a load
//   EXMEM_RegDst   in   5   destination register of the instruction in MEM
//   EXMEM_RegWrite in   1   MEM instruction writes the register file
//   RedirectIn     in   1   EX resolved a taken branch, jump or jr this cycle
//   PCWrite        out  1   1 = PC may update
//   IFDEC_write    out  1   1 = IF/DEC register may load
//   IFDEC_flush    out  1   1 = IF/DEC register loads a NOP
//   DECEX_stall    out  1   1 = DEC/EX register loads a NOP (bubble)
//   StallCount     out  32  cycles spent in hazard stall, saturating
//   FlushCount     out  32  cycles spent flushing, saturating
// BEHAVIOUR
//   Reset: state=RUN, FlushCnt=0, StallCount=0, FlushCount=0.
//     While Reset=1, force PCWrite=1, IFDEC_write=1, IFDEC_flush=0, DECEX_stall=0.
//   Match rules:
//     matchX(r)  = X_RegWrite && X_RegDst==r && r!=0.
//     hazRs      = UseRsIn && (FORWARDING ? matchDECEX(Rs) && DECEX_MemRead
//                                         : matchDECEX(Rs) || matchEXMEM(Rs)); hazRt is the same with Rt.
//     haz        = hazRs || hazRt. Register $0 never causes a hazard.
//     The register file writes in the first half-cycle and reads in the second, so WB-stage writers are never hazards.
//   Outputs are combinational from state and inputs: zero added latency, same-cycle effect.
//   State RUN:
//     RedirectIn=1 (has priority over haz):
//       IFDEC_flush=1, DECEX_stall=1, PCWrite=1, IFDEC_write=1, FlushCount+=1.
//       If FLUSH_CYCLES>1: FlushCnt<=FLUSH_CYCLES-1, next state FLUSH; else stay in RUN.
//     haz=1, RedirectIn=0:
//       PCWrite=0, IFDEC_write=0, DECEX_stall=1, IFDEC_flush=0, StallCount+=1. Stay in RUN.
//       The hazard re-evaluates every cycle and clears as the writer advances. Max 1 cycle for FORWARDING=1, 2 for 0.
//     Otherwise: PCWrite=1, IFDEC_write=1, IFDEC_flush=0, DECEX_stall=0.
//   State FLUSH:
//     Outputs: IFDEC_flush=1, DECEX_stall=1, PCWrite=1, IFDEC_write=1, FlushCount+=1, FlushCnt-=1.
//     haz and RedirectIn are ignored; only bubbles are in flight.
//     When FlushCnt==1 this cycle, next state is RUN.
//   Counters saturate at 32'hFFFF_FFFF with no wrap. Each counter increments at most once per cycle.
//   A cycle counts as stall or flush, never both.
//   Reset mid-FLUSH or mid-stall: next cycle is RUN with counters zero. No residual flush.
//   Undefined inputs (X) on Use*/RegWrite must not be masked; the bench checks with known values only.
// TESTING
//   T1 Reset: hold Reset 2 cycles with RedirectIn=1 -> PCWrite=1, DECEX_stall=0, IFDEC_flush=0, counters=0.
//   T2 Load-use, FORWARDING=1: DECEX_RegDst=8, RegWrite=1, MemRead=1; RsIn=8, UseRsIn=1
//      -> DECEX_stall=1, PCWrite=0 for exactly 1 cycle; StallCount=1.
//   T3 No forwarding, FORWARDING=0: EXMEM_RegDst=9, RegWrite=1; RtIn=9, UseRtIn=1 -> stall asserted.
//      Same setup with RegDst=0 and RtIn=0 -> no stall.
//   T4 Redirect priority: haz=1 and RedirectIn=1 in the same cycle
//      -> IFDEC_flush=1, DECEX_stall=1, PCWrite=1; FlushCount=1, StallCount unchanged.
//   T5 FLUSH_CYCLES=3: one-cycle RedirectIn pulse -> IFDEC_flush high for exactly 3 cycles.
//      A second RedirectIn during FLUSH does not extend it. FlushCount=3.
//   T6 Saturation/reset: preload StallCount near max via force, hold haz -> sticks at FFFF_FFFF.
//      Reset asserted during FLUSH -> RUN and zero counters next cycle.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//   Bundles the DEC-stage operand info, the EX/MEM writer info, the redirect
//   request and the resulting pipeline hold/bubble controls and counters
//   exchanged between the pipeline datapath and hazard_stall_ctrl.
//
//   slave  : the hazard controller (consumes operand/writer info, drives controls)
//   master : the pipeline side (drives operand/writer info, consumes controls)
//
//   Signals
//     RsIn, RtIn, UseRsIn, UseRtIn        DEC-stage source operands
//     DECEX_RegDst/RegWrite/MemRead       instruction currently in EX
//     EXMEM_RegDst/RegWrite               instruction currently in MEM
//     RedirectIn                          taken branch/jump/jr resolved in EX
//     PCWrite, IFDEC_write, IFDEC_flush,
//     DECEX_stall                         pipeline register controls
//     StallCount, FlushCount              saturating performance counters
// ----------------------------------------------------------------------------
interface hazard_stall_ctrl_if;
    logic [4:0]  RsIn;
    logic [4:0]  RtIn;
    logic        UseRsIn;
    logic        UseRtIn;
    logic [4:0]  DECEX_RegDst;
    logic        DECEX_RegWrite;
    logic        DECEX_MemRead;
    logic [4:0]  EXMEM_RegDst;
    logic        EXMEM_RegWrite;
    logic        RedirectIn;
    logic        PCWrite;
    logic        IFDEC_write;
    logic        IFDEC_flush;
    logic        DECEX_stall;
    logic [31:0] StallCount;
    logic [31:0] FlushCount;

    modport slave (
        input  RsIn, RtIn, UseRsIn, UseRtIn,
        input  DECEX_RegDst, DECEX_RegWrite, DECEX_MemRead,
        input  EXMEM_RegDst, EXMEM_RegWrite,
        input  RedirectIn,
        output PCWrite, IFDEC_write, IFDEC_flush, DECEX_stall,
        output StallCount, FlushCount
    );

    modport master (
        output RsIn, RtIn, UseRsIn, UseRtIn,
        output DECEX_RegDst, DECEX_RegWrite, DECEX_MemRead,
        output EXMEM_RegDst, EXMEM_RegWrite,
        output RedirectIn,
        input  PCWrite, IFDEC_write, IFDEC_flush, DECEX_stall,
        input  StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Produces the hold/bubble controls for the IF/DEC and DEC/EX pipeline
//   registers. Detects RAW hazards between the DEC instruction and older
//   in-flight writers, squashes wrong-path instructions after a redirect via a
//   small flush state machine, and keeps saturating stall/flush cycle counters.
//
//   Parameters
//     FORWARDING   1: stall only on load-use; 0: stall on any EX/MEM writer
//     FLUSH_CYCLES cycles IFDEC_flush is held per redirect (1..7)
//
//   Ports
//     Clk    system clock, all state on posedge
//     Reset  synchronous, active-high
//     bus    hazard_stall_ctrl_if.slave (operand/writer info in, controls out)
//
//   Controls are combinational from state and inputs, so a hazard or redirect
//   takes effect in the same cycle it is presented.
// ----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int FORWARDING   = 1,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    hazard_stall_ctrl_if.slave   bus
);

    typedef enum logic {RUN, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [2:0]  flushCnt;
    logic [31:0] stallCntQ;
    logic [31:0] flushCntQ;

    logic matchExRs, matchExRt, matchMemRs, matchMemRt;
    logic hazRs, hazRt, haz;
    logic pcWrite, ifdecWrite, ifdecFlush, decexStall;
    logic stallInc, flushInc;

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Register $0 is hard-wired to zero, so it never creates a dependency.
    assign matchExRs  = bus.DECEX_RegWrite && (bus.DECEX_RegDst == bus.RsIn) && (bus.RsIn != 5'd0);
    assign matchExRt  = bus.DECEX_RegWrite && (bus.DECEX_RegDst == bus.RtIn) && (bus.RtIn != 5'd0);
    assign matchMemRs = bus.EXMEM_RegWrite && (bus.EXMEM_RegDst == bus.RsIn) && (bus.RsIn != 5'd0);
    assign matchMemRt = bus.EXMEM_RegWrite && (bus.EXMEM_RegDst == bus.RtIn) && (bus.RtIn != 5'd0);

    // With forwarding, only a load in EX is too late to forward from.
    // WB-stage writers are never hazards: the register file writes first-half.
    always_comb begin
        if (FORWARDING != 0) begin
            hazRs = bus.UseRsIn && matchExRs && bus.DECEX_MemRead;
            hazRt = bus.UseRtIn && matchExRt && bus.DECEX_MemRead;
        end else begin
            hazRs = bus.UseRsIn && (matchExRs || matchMemRs);
            hazRt = bus.UseRtIn && (matchExRt || matchMemRt);
        end
    end

    assign haz = hazRs || hazRt;

    // Redirect outranks a hazard: the stalled instruction is wrong-path anyway.
    // During FLUSH only bubbles are in flight, so haz/RedirectIn are ignored.
    always_comb begin
        pcWrite    = 1'b1;
        ifdecWrite = 1'b1;
        ifdecFlush = 1'b0;
        decexStall = 1'b0;
        stallInc   = 1'b0;
        flushInc   = 1'b0;
        if (!Reset) begin
            if (state == FLUSH || bus.RedirectIn) begin
                ifdecFlush = 1'b1;
                decexStall = 1'b1;
                flushInc   = 1'b1;
            end else if (haz) begin
                pcWrite    = 1'b0;
                ifdecWrite = 1'b0;
                decexStall = 1'b1;
                stallInc   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= RUN;
            flushCnt  <= 3'd0;
            stallCntQ <= 32'd0;
            flushCntQ <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.RedirectIn && FLUSH_CYCLES > 1) begin
                        flushCnt <= FLUSH_LOAD;
                        state    <= FLUSH;
                    end
                end
                FLUSH: begin
                    flushCnt <= flushCnt - 3'd1;
                    if (flushCnt == 3'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
            if (stallInc)
                stallCntQ <= satInc(stallCntQ);
            if (flushInc)
                flushCntQ <= satInc(flushCntQ);
        end
    end

    assign bus.PCWrite     = pcWrite;
    assign bus.IFDEC_write = ifdecWrite;
    assign bus.IFDEC_flush = ifdecFlush;
    assign bus.DECEX_stall = decexStall;
    assign bus.StallCount  = stallCntQ;
    assign bus.FlushCount  = flushCntQ;

endmodule
